// File: rtl/irq_gateway_if.sv
// Register-bus types and the interface that carries the shared
// system-peripheral bus, block select and read data into irq_gateway.
package irq_gateway_pkg;
  typedef struct packed {
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [31:0] wdata;
  } sys_peripheral_t;

  typedef struct packed {
    logic wen;
    logic ren;
  } sel_t;
endpackage

// Handshake: sel.wen / sel.ren act as valid with no ready. A write or read is
// accepted on every rising edge where its enable is high, and rdata updates
// on the edge that accepts the read.
interface irq_gateway_if;
  import irq_gateway_pkg::*;

  sys_peripheral_t sys_share;
  sel_t            sel;
  logic [31:0]     rdata;

  modport master (output sys_share, output sel, input rdata);
  modport slave  (input sys_share, input sel, output rdata);
endinterface

// File: rtl/irq_gateway.sv
// Interrupt pin conditioner: 2-flop sync, per-source stability filter,
// polarity select, level/edge mode with W1C latch, registered request output.
module irq_gateway
  import irq_gateway_pkg::*;
#(
  parameter int INT_NUM  = 32,
  parameter int FILT_LEN = 4
) (
  input  logic               hb_clk,
  input  logic               rst_n,
  irq_gateway_if.slave       bus,
  input  logic [INT_NUM-1:0] irq_pin,
  output logic [INT_NUM-1:0] irq_source
);

  localparam logic [3:0] CNT_MAX = 4'(FILT_LEN - 1);

  localparam logic [31:0] ADDR_MODE  = 32'h0;
  localparam logic [31:0] ADDR_POL   = 32'h4;
  localparam logic [31:0] ADDR_LATCH = 32'h8;
  localparam logic [31:0] ADDR_RAW   = 32'hC;

  logic [INT_NUM-1:0] s1, s2, filt, prev;
  logic [INT_NUM-1:0] mode, pol, latch;
  logic [3:0]         cnt [INT_NUM];

  logic [INT_NUM-1:0] wr_data, mode_nxt, mode_chg, latch_w1c;
  logic [INT_NUM-1:0] act, act_prev, edge_set, latch_nxt;
  logic               mode_we, pol_we;
  logic [31:0]        rd_val;

  always_comb begin
    wr_data   = bus.sys_share.wdata[INT_NUM-1:0];
    mode_we   = bus.sel.wen && (bus.sys_share.waddr == ADDR_MODE);
    pol_we    = bus.sel.wen && (bus.sys_share.waddr == ADDR_POL);
    latch_w1c = (bus.sel.wen && (bus.sys_share.waddr == ADDR_LATCH)) ? wr_data : '0;
    mode_nxt  = mode_we ? wr_data : mode;
    mode_chg  = mode_nxt ^ mode;
    act       = filt ^ pol;
    act_prev  = prev ^ pol;
    edge_set  = mode & act & ~act_prev;
    // A fresh edge beats W1C; a mode flip on that bit clears it regardless.
    latch_nxt = ((latch & ~latch_w1c) | edge_set) & ~mode_chg;
  end

  always_comb begin
    rd_val = '0;
    case (bus.sys_share.raddr)
      ADDR_MODE:  rd_val = 32'(mode);
      ADDR_POL:   rd_val = 32'(pol);
      ADDR_LATCH: rd_val = 32'(latch);
      ADDR_RAW:   rd_val = 32'(filt);
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      filt <= '0;
      prev <= '0;
      for (int i = 0; i < INT_NUM; i++) cnt[i] <= '0;
    end else begin
      s1   <= irq_pin;
      s2   <= s1;
      prev <= filt;
      for (int i = 0; i < INT_NUM; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode       <= '0;
      pol        <= '0;
      latch      <= '0;
      irq_source <= '0;
      bus.rdata  <= '0;
    end else begin
      mode       <= mode_nxt;
      if (pol_we) pol <= wr_data;
      latch      <= latch_nxt;
      irq_source <= (mode & latch) | (~mode & act);
      if (bus.sel.ren) bus.rdata <= rd_val;
    end
  end

endmodule
